// File: rtl/ov7670_capture_ctrl_if.sv
// Sensor pixel bus and frame-buffer write port of the OV7670 capture controller.
interface ov7670_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 15
) ();
    logic              href;
    logic              vsync;
    logic [7:0]        data;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [15:0]       wData;

    modport master (
        input  href, vsync, data,
        output we, wAddr, wData
    );

    modport slave (
        output href, vsync, data,
        input  we, wAddr, wData
    );
endinterface

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 RGB565 capture into a ping-pong frame buffer, with optional grayscale
// conversion and 2:1 decimation; frames are validated before the buffer is swapped.
module ov7670_capture_ctrl #(
    parameter int unsigned H_PIXELS   = 160,
    parameter int unsigned V_PIXELS   = 120,
    parameter int unsigned FRAME_SIZE = H_PIXELS * V_PIXELS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ov7670_capture_ctrl_if.master bus,
    input  logic                  enable,
    input  logic                  gray_mode,
    input  logic                  half_scale,
    output logic                  buffer_sel,
    output logic                  rd_buffer,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);
    localparam int unsigned ADDR_W    = $clog2(FRAME_SIZE);
    localparam int unsigned CNT_W     = $clog2(FRAME_SIZE + 1);
    localparam int unsigned COL_W     = $clog2(H_PIXELS + 2);
    localparam int unsigned LINE_W    = $clog2(V_PIXELS + 2);
    localparam int unsigned HALF_SIZE = (H_PIXELS / 2) * (V_PIXELS / 2);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

    state_t            state;
    logic              vsync_d;
    logic              href_d;
    logic              byte_tog;
    logic [7:0]        hi_byte;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic              err_flag;
    logic              gray_l;
    logic              half_l;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              line_end;
    logic              line_bad;
    logic              col_keep;
    logic              frame_good;
    logic [CNT_W-1:0]  exp_words;
    logic [LINE_W:0]   line_total;
    logic [15:0]       pixel;
    logic [7:0]        r8, g8, b8;
    logic [15:0]       ysum;
    logic [15:0]       gray_word;

    // Edge detection, frame judgement and pixel conversion.
    always_comb begin
        vsync_rise = bus.vsync & ~vsync_d;
        vsync_fall = ~bus.vsync & vsync_d;
        line_end   = href_d & ~bus.href;
        line_bad   = line_end && (col_cnt != COL_W'(H_PIXELS));
        col_keep   = !half_l || (!col_cnt[0] && !line_cnt[0]);
        exp_words  = half_l ? CNT_W'(HALF_SIZE) : CNT_W'(FRAME_SIZE);
        line_total = {1'b0, line_cnt} + (LINE_W + 1)'(line_end);
        // A high href at frame end means the last line was cut short.
        frame_good = !err_flag && !bus.href && !line_bad
                     && (line_total == (LINE_W + 1)'(V_PIXELS))
                     && (word_cnt == exp_words);
        pixel      = {hi_byte, bus.data};
        r8         = {pixel[15:11], pixel[15:13]};
        g8         = {pixel[10:5],  pixel[10:9]};
        b8         = {pixel[4:0],   pixel[4:2]};
        ysum       = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
        gray_word  = {ysum[15:11], ysum[15:10], ysum[15:11]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            byte_tog   <= 1'b0;
            hi_byte    <= '0;
            col_cnt    <= '0;
            line_cnt   <= '0;
            word_cnt   <= '0;
            err_flag   <= 1'b0;
            gray_l     <= 1'b0;
            half_l     <= 1'b0;
            bus.we     <= 1'b0;
            bus.wAddr  <= '0;
            bus.wData  <= '0;
            buffer_sel <= 1'b0;
            rd_buffer  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_d    <= bus.vsync;
            href_d     <= bus.href;
            bus.we     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= SYNC;
                end
                SYNC: begin
                    if (vsync_fall) begin
                        state    <= CAPTURE;
                        gray_l   <= gray_mode;
                        half_l   <= half_scale;
                        col_cnt  <= '0;
                        line_cnt <= '0;
                        word_cnt <= '0;
                        err_flag <= 1'b0;
                        byte_tog <= 1'b0;
                    end else if (vsync_rise && !enable) begin
                        state <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        if (frame_good) begin
                            frame_done <= 1'b1;
                            rd_buffer  <= buffer_sel;
                            buffer_sel <= ~buffer_sel;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        byte_tog <= 1'b0;
                        state    <= enable ? SYNC : IDLE;
                    end else begin
                        if (line_end) begin
                            if (line_bad) err_flag <= 1'b1;
                            col_cnt <= '0;
                            if (line_cnt != LINE_W'(V_PIXELS + 1)) line_cnt <= line_cnt + LINE_W'(1);
                        end
                        if (bus.href) begin
                            byte_tog <= ~byte_tog;
                            if (!byte_tog) begin
                                hi_byte <= bus.data;
                            end else begin
                                if (col_cnt != COL_W'(H_PIXELS + 1)) col_cnt <= col_cnt + COL_W'(1);
                                // Past the expected word count the buffer is protected.
                                if (col_keep) begin
                                    if (word_cnt < exp_words) begin
                                        bus.we    <= 1'b1;
                                        bus.wAddr <= ADDR_W'(word_cnt);
                                        bus.wData <= gray_l ? gray_word : pixel;
                                        word_cnt  <= word_cnt + CNT_W'(1);
                                    end else begin
                                        err_flag <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            byte_tog <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed-frame bench for ov7670_capture_ctrl on a reduced 8x6 sensor, with a write scoreboard.
module tb_ov7670_capture_ctrl;
    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable, gray_mode, half_scale;
    logic        buffer_sel, rd_buffer, frame_done, frame_err;
    logic [15:0] frame_cnt;

    ov7670_capture_ctrl_if #(.ADDR_W(6)) bus ();

    ov7670_capture_ctrl #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .enable(enable),
        .gray_mode(gray_mode), .half_scale(half_scale), .buffer_sel(buffer_sel),
        .rd_buffer(rd_buffer), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] expq[$];
    int          wr_count, done_cnt, err_cnt;
    logic [15:0] first_data[4];
    logic        first_bsel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int l, input int c);
        if (l == 0 && c == 0) return 16'hF800;
        if (l == 0 && c == 1) return 16'hFFFF;
        return 16'((l * 1057) ^ (c * 4951) ^ 42435);
    endfunction

    function automatic logic [15:0] to_gray(input logic [15:0] p);
        int r, g, b, y;
        r = (int'(p[15:11]) << 3) | (int'(p[15:11]) >> 2);
        g = (int'(p[10:5]) << 2) | (int'(p[10:5]) >> 4);
        b = (int'(p[4:0]) << 3) | (int'(p[4:0]) >> 2);
        y = ((77 * r + 150 * g + 29 * b) >> 8) & 255;
        return 16'(((y >> 3) << 11) | ((y >> 2) << 5) | (y >> 3));
    endfunction

    // Write monitor: every write must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (bus.we) begin
            if (wr_count < 4) first_data[wr_count] = bus.wData;
            if (wr_count == 0) first_bsel = buffer_sel;
            wr_count++;
            tests++;
            assert (expq.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", bus.wAddr, bus.wData);
            end
            if (expq.size() != 0) check("write", {16'(bus.wAddr), bus.wData}, expq.pop_front());
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic drive_frame(input bit g, input bit h, input int short_line,
                               input int drop_line, input bit expect_wr, input bit flip);
        int words, limit, n;
        logic [15:0] p;
        wr_count = 0; done_cnt = 0; err_cnt = 0;
        words = 0;
        limit = h ? (H / 2) * (V / 2) : H * V;
        gray_mode = g; half_scale = h;
        bus.vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
        if (flip) begin gray_mode = ~g; half_scale = ~h; end
        for (int l = 0; l < V; l++) begin
            if (l == drop_line) enable = 1'b0;
            n = (l == short_line) ? H - 1 : H;
            bus.href = 1'b1;
            for (int c = 0; c < n; c++) begin
                p = pix(l, c);
                bus.data = p[15:8];
                @(negedge clk);
                bus.data = p[7:0];
                if (expect_wr && (!h || ((c % 2 == 0) && (l % 2 == 0))) && words < limit) begin
                    expq.push_back({16'(words), g ? to_gray(p) : p});
                    words++;
                end
                @(negedge clk);
            end
            bus.href = 1'b0;
            bus.data = 8'h00;
            repeat (3) @(negedge clk);
        end
        bus.vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_check(input string tag, input int ewr, input int edone, input int eerr,
                               input logic ebsel, input logic erd, input int ecnt);
        check({tag, "_pending"}, expq.size(), 0);
        expq.delete();
        check({tag, "_writes"}, wr_count, ewr);
        check({tag, "_done"}, done_cnt, edone);
        check({tag, "_err"}, err_cnt, eerr);
        check({tag, "_buffer_sel"}, buffer_sel, ebsel);
        check({tag, "_rd_buffer"}, rd_buffer, erd);
        check({tag, "_frame_cnt"}, frame_cnt, ecnt);
    endtask

    initial begin
        logic [15:0] p;
        reset_n = 1'b0; enable = 1'b0; gray_mode = 1'b0; half_scale = 1'b0;
        bus.href = 1'b0; bus.vsync = 1'b0; bus.data = 8'h00;
        wr_count = 0; done_cnt = 0; err_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.wAddr, 0);
        check("rst_wdata", bus.wData, 0);
        check("rst_outs", {buffer_sel, rd_buffer, frame_done, frame_err}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        drive_frame(0, 0, -1, -1, 1, 0);
        frame_check("rgb", H * V, 1, 0, 1, 0, 1);

        drive_frame(1, 0, -1, -1, 1, 0);
        frame_check("gray", H * V, 1, 0, 0, 1, 2);
        check("gray_red", first_data[0], 16'h4A69);
        check("gray_white", first_data[1], 16'hFFFF);

        drive_frame(0, 1, -1, -1, 1, 0);
        frame_check("half", (H / 2) * (V / 2), 1, 0, 1, 0, 3);
        check("half_px0", first_data[0], pix(0, 0));
        check("half_px2", first_data[1], pix(0, 2));
        check("half_px4", first_data[2], pix(0, 4));

        drive_frame(0, 0, 2, -1, 1, 0);
        frame_check("short", H * V - 1, 0, 1, 1, 0, 3);
        check("short_bsel", first_bsel, 1);

        drive_frame(0, 0, -1, -1, 1, 1);
        frame_check("rewrite", H * V, 1, 0, 0, 1, 4);
        check("rewrite_bsel", first_bsel, 1);

        drive_frame(0, 0, -1, 3, 1, 0);
        frame_check("drop", H * V, 1, 0, 1, 0, 5);
        drive_frame(0, 0, -1, -1, 0, 0);
        frame_check("idle", 0, 0, 0, 1, 0, 5);

        // Reset in the middle of the first line of a frame.
        enable = 1'b1; gray_mode = 1'b0; half_scale = 1'b0;
        repeat (3) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
        bus.href = 1'b1;
        for (int c = 0; c < 3; c++) begin
            p = pix(0, c);
            bus.data = p[15:8];
            @(negedge clk);
            bus.data = p[7:0];
            expq.push_back({16'(c), p});
            @(negedge clk);
        end
        p = pix(0, 3);
        bus.data = p[15:8];
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", bus.we, 0);
        check("mid_rst_waddr", bus.wAddr, 0);
        check("mid_rst_wdata", bus.wData, 0);
        check("mid_rst_outs", {buffer_sel, rd_buffer, frame_done, frame_err}, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_pending", expq.size(), 0);
        bus.href = 1'b0; bus.data = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        drive_frame(0, 0, -1, -1, 1, 0);
        frame_check("post_rst", H * V, 1, 0, 1, 0, 1);
        check("post_rst_bsel", first_bsel, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ov7670_capture_ctrl.md
OV7670_CAPTURE_CTRL -- requirements
Module: ov7670_capture_ctrl

Interface
REQ-001 SHALL have parameters: H_PIXELS, default 160, sensor active pixels per line; V_PIXELS, default 120, sensor lines per frame; FRAME_SIZE, default H_PIXELS*V_PIXELS, words per buffer.
REQ-002 SHALL have one clock and one asynchronous active-low reset; ports listed below, clock and reset first.
REQ-003 clk  in  1  sole clock; pixel byte sampled on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 href  in  1  line-valid from sensor.
REQ-006 vsync  in  1  frame sync from sensor; high = vertical blanking.
REQ-007 data  in  8  sensor byte, RGB565, high byte first.
REQ-008 enable  in  1  capture enable.
REQ-009 gray_mode  in  1  0 = RGB565 pass-through, 1 = grayscale.
REQ-010 half_scale  in  1  1 = 2:1 decimation in both axes.
REQ-011 we  out  1  memory write strobe.
REQ-012 wAddr  out  $clog2(FRAME_SIZE)  write address.
REQ-013 wData  out  16  write data.
REQ-014 buffer_sel  out  1  buffer being written.
REQ-015 rd_buffer  out  1  last completed buffer, for display.
REQ-016 frame_done  out  1  one-cycle pulse on good frame.
REQ-017 frame_err  out  1  one-cycle pulse on bad frame.
REQ-018 frame_cnt  out  16  good frames since reset, wraps.

Function
REQ-019 FSM states SHALL be IDLE, SYNC, CAPTURE.
- IDLE -> SYNC when enable=1.
- SYNC -> CAPTURE on vsync falling edge.
- CAPTURE -> SYNC on vsync rising edge (frame end).
- CAPTURE/SYNC -> IDLE only at frame end with enable=0.
REQ-020 gray_mode and half_scale SHALL be latched on SYNC -> CAPTURE and held for the whole frame.
REQ-021 In CAPTURE, a byte toggle SHALL pair bytes while href=1: first byte = pixel[15:8], second = pixel[7:0]; the toggle clears whenever href=0.
REQ-022 we, wAddr, wData SHALL be registered and asserted 1 cycle after the second byte of a kept pixel; we SHALL be 0 otherwise.
REQ-023 First kept pixel of a frame SHALL write address 0; wAddr SHALL increment by 1 after each write.
REQ-024 half_scale=1: keep a pixel only when both column index and line index are even; output frame is (H_PIXELS/2)*(V_PIXELS/2) words.
REQ-025 Grayscale arithmetic:
- R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Y = (77*R8 + 150*G8 + 29*B8)[15:8], 16-bit unsigned sum.
- wData = {Y[7:3],Y[7:2],Y[7:3]}.
REQ-026 On each href falling edge in CAPTURE, the raw pixel count SHALL equal H_PIXELS; otherwise the frame error flag is set.
REQ-027 Writes SHALL be suppressed once the expected output word count is reached; any excess pixel sets the frame error flag.
REQ-028 Good frame end (line count = V_PIXELS, word count = expected, no error flag):
- frame_done pulses.
- rd_buffer <= buffer_sel; buffer_sel toggles.
- frame_cnt increments.
REQ-029 Bad frame end: frame_err pulses; buffer_sel, rd_buffer and frame_cnt are unchanged, so the same buffer is overwritten.
REQ-030 enable=0 mid-frame SHALL take effect only at frame end; that frame is still completed and judged.
REQ-031 A vsync rising edge while href=1 SHALL end the frame and count the partial line as a length error.

Reset
REQ-032 On reset_n=0, immediately:
- FSM = IDLE.
- we, wAddr, wData, buffer_sel, rd_buffer, frame_done, frame_err, frame_cnt, all counters, flags and the byte toggle = 0.
REQ-033 Reset asserted mid-frame SHALL abort capture with no write and no frame_done/frame_err pulse.

Verification
REQ-034 Good 160x120 RGB565 frame, enable=1 -> 19200 writes at addresses 0..19199, wData = {byte0,byte1}, frame_done once, buffer_sel 0->1, rd_buffer=0, frame_cnt=1.
REQ-035 gray_mode=1, pixel 0xF800 (pure red) -> wData=0x4A69 (Y=0x4C); pixel 0xFFFF -> 0xFFFF.
REQ-036 half_scale=1, full frame -> 4800 writes; first writes carry raw pixels 0, 2, 4; line 1 produces no writes.
REQ-037 One line of 159 pixels -> frame_err pulse, buffer_sel unchanged, frame_cnt unchanged; the next good frame writes the same buffer.
REQ-038 enable dropped mid-frame -> frame finishes with frame_done, FSM then IDLE, no further writes.
REQ-039 reset_n pulsed low mid-line -> all outputs 0 at once; next full frame behaves as in REQ-034.
